// File: rtl/dcache_load_unit_pkg.sv
// Shared definitions for the MEM-stage load-return path: funct3 load codes
// and the load FSM state type.
package dcache_load_unit_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      HOLD = 2'b10
   } ld_state_t;

endpackage

// File: rtl/dcache_load_unit_load_extend.sv
// Combinational byte/halfword/word extraction with sign/zero extension and
// alignment / funct3 legality check.
module load_extend
   import dcache_load_unit_pkg::*;
#(
   parameter int data_size = 32
) (
   input  logic [data_size-1:0] word,
   input  logic [2:0]           load_type,
   input  logic [1:0]           offset,
   output logic [data_size-1:0] data,
   output logic                 err
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[8*offset +: 8];
      half_sel = word[16*offset[1] +: 16];
      data     = '0;
      err      = 1'b0;
      // Any error forces the data to zero so a faulting load never leaks bytes.
      case (load_type)
         LB:  data = {{(data_size-8){byte_sel[7]}}, byte_sel};
         LBU: data = {{(data_size-8){1'b0}}, byte_sel};
         LH: begin
            if (offset[0]) err = 1'b1;
            else           data = {{(data_size-16){half_sel[15]}}, half_sel};
         end
         LHU: begin
            if (offset[0]) err = 1'b1;
            else           data = {{(data_size-16){1'b0}}, half_sel};
         end
         LW: begin
            if (offset != 2'b00) err = 1'b1;
            else                 data = word;
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/dcache_load_unit.sv
// MEM-stage load return: waits out D-cache misses, extends the addressed
// data and buffers the result while the rest of the pipeline is frozen.
module dcache_load_unit
   import dcache_load_unit_pkg::*;
#(
   parameter int data_size = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 MemRead_MEM,
   input  logic [2:0]           load_type,
   input  logic [1:0]           addr_offset,
   input  logic [data_size-1:0] Dcache_out,
   input  logic                 DC_stall,
   input  logic                 pipe_stall,
   output logic                 stall_MEM,
   output logic [data_size-1:0] load_data,
   output logic                 load_valid,
   output logic                 load_err
);

   ld_state_t state, state_nx;

   logic [2:0]           ld_type_p0;
   logic [1:0]           ld_off_p0;
   logic [data_size-1:0] hold_data_p1;
   logic                 hold_err_p1;

   logic [2:0]           ext_type;
   logic [1:0]           ext_off;
   logic [data_size-1:0] ext_data;
   logic                 ext_err;
   logic [data_size-1:0] ret_data;
   logic                 ret_err;
   logic                 accept;
   logic                 capture;
   logic                 fire;

   // The live request fields are only trusted on the accepting cycle.
   assign ext_type = (state == IDLE) ? load_type   : ld_type_p0;
   assign ext_off  = (state == IDLE) ? addr_offset : ld_off_p0;
   assign ret_data = (state == HOLD) ? hold_data_p1 : ext_data;
   assign ret_err  = (state == HOLD) ? hold_err_p1  : ext_err;

   load_extend #(
      .data_size (data_size)
   ) u_load_extend (
      .word      (Dcache_out),
      .load_type (ext_type),
      .offset    (ext_off),
      .data      (ext_data),
      .err       (ext_err)
   );

   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      capture   = 1'b0;
      fire      = 1'b0;
      stall_MEM = 1'b0;
      case (state)
         IDLE: begin
            if (MemRead_MEM) begin
               accept = 1'b1;
               if (DC_stall) begin
                  stall_MEM = 1'b1;
                  state_nx  = WAIT;
               end else if (pipe_stall) begin
                  capture  = 1'b1;
                  state_nx = HOLD;
               end else begin
                  fire = 1'b1;
               end
            end
         end
         WAIT: begin
            stall_MEM = 1'b1;
            if (!DC_stall) begin
               if (pipe_stall) begin
                  capture  = 1'b1;
                  state_nx = HOLD;
               end else begin
                  fire     = 1'b1;
                  state_nx = IDLE;
               end
            end
         end
         HOLD: begin
            if (!pipe_stall) begin
               fire     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // stage p0: request fields / held word; p1: registered result to MEM/WB
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ld_type_p0   <= '0;
         ld_off_p0    <= '0;
         hold_data_p1 <= '0;
         hold_err_p1  <= 1'b0;
         load_data    <= '0;
         load_err     <= 1'b0;
         load_valid   <= 1'b0;
      end else begin
         state      <= state_nx;
         load_valid <= fire;
         if (accept) begin
            ld_type_p0 <= load_type;
            ld_off_p0  <= addr_offset;
         end
         if (capture) begin
            hold_data_p1 <= ext_data;
            hold_err_p1  <= ext_err;
         end
         if (fire) begin
            load_data <= ret_data;
            load_err  <= ret_err;
         end
      end
   end

endmodule

// File: tb/tb_dcache_load_unit.sv
// Bench for dcache_load_unit: directed cases plus randomized loads scored
// against a transaction-level reference of the load-return behaviour.
module tb_dcache_load_unit;

   logic        clk;
   logic        rst;
   logic        MemRead_MEM;
   logic [2:0]  load_type;
   logic [1:0]  addr_offset;
   logic [31:0] Dcache_out;
   logic        DC_stall;
   logic        pipe_stall;
   logic        stall_MEM;
   logic [31:0] load_data;
   logic        load_valid;
   logic        load_err;

   int checks = 0;
   int errors = 0;

   dcache_load_unit #(
      .data_size (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .MemRead_MEM (MemRead_MEM),
      .load_type   (load_type),
      .addr_offset (addr_offset),
      .Dcache_out  (Dcache_out),
      .DC_stall    (DC_stall),
      .pipe_stall  (pipe_stall),
      .stall_MEM   (stall_MEM),
      .load_data   (load_data),
      .load_valid  (load_valid),
      .load_err    (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   // Reference result of a load, from arithmetic on the shifted word.
   function automatic void ref_load(input logic [31:0] w, input logic [2:0] t,
                                    input logic [1:0] o, output logic [31:0] d,
                                    output logic e);
      logic [31:0] sh, b, h;
      sh = w >> (8 * o);
      b  = sh & 32'h0000_00FF;
      h  = sh & 32'h0000_FFFF;
      e  = 1'b0;
      d  = 32'h0;
      case (t)
         3'b000: d = (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
         3'b100: d = b;
         3'b001: begin e = (o % 2) != 0; d = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h; end
         3'b101: begin e = (o % 2) != 0; d = h; end
         3'b010: begin e = (o != 0); d = w; end
         default: e = 1'b1;
      endcase
      if (e) d = 32'h0;
   endfunction

   // One load: DC_stall high for `miss` cycles starting at the request cycle,
   // then pipe_stall high for `ps` cycles from the cycle the word arrives.
   task automatic run_load(input string name, input logic [31:0] word, input logic [2:0] t,
                           input logic [1:0] o, input int miss, input int ps);
      logic [31:0] exp_d;
      logic        exp_e;
      logic        exp_stall;
      int          c;
      ref_load(word, t, o, exp_d, exp_e);
      c = miss;
      for (int i = 0; i <= miss + ps; i++) begin
         @(negedge clk);
         if (i == 0) begin
            MemRead_MEM = 1'b1;
            load_type   = t;
            addr_offset = o;
         end else begin
            MemRead_MEM = 1'($urandom_range(0, 1));
            load_type   = 3'($urandom_range(0, 7));
            addr_offset = 2'($urandom_range(0, 3));
         end
         if (i < miss)       DC_stall = 1'b1;
         else if (i == c)    DC_stall = 1'b0;
         else                DC_stall = 1'($urandom_range(0, 1));
         if (i < c)          pipe_stall = 1'($urandom_range(0, 1));
         else                pipe_stall = (i < c + ps);
         Dcache_out = (i == c) ? word : $urandom;
         #1;
         exp_stall = (miss > 0) && (i <= c);
         checks++;
         if (stall_MEM !== exp_stall) begin
            errors++;
            $display("FAIL %s stall_MEM cyc=%0d got=%0b exp=%0b", name, i, stall_MEM, exp_stall);
         end
         checks++;
         if (load_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early_valid cyc=%0d got=%0b exp=0", name, i, load_valid);
         end
      end
      @(negedge clk);
      MemRead_MEM = 1'b0;
      DC_stall    = 1'b0;
      pipe_stall  = 1'b0;
      Dcache_out  = $urandom;
      #1;
      checks++;
      if (load_valid !== 1'b1 || load_data !== exp_d || load_err !== exp_e) begin
         errors++;
         $display("FAIL %s result valid=%0b data=%h err=%0b exp valid=1 data=%h err=%0b",
                  name, load_valid, load_data, load_err, exp_d, exp_e);
      end
      @(negedge clk);
      #1;
      checks++;
      if (load_valid !== 1'b0 || load_data !== exp_d || load_err !== exp_e) begin
         errors++;
         $display("FAIL %s after_pulse valid=%0b data=%h err=%0b exp valid=0 data=%h err=%0b",
                  name, load_valid, load_data, load_err, exp_d, exp_e);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      MemRead_MEM = 1'b0; load_type = 3'b000; addr_offset = 2'b00;
      Dcache_out = 32'h0; DC_stall = 1'b0; pipe_stall = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (load_data !== 32'h0 || load_valid !== 1'b0 || load_err !== 1'b0 || stall_MEM !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs data=%h valid=%0b err=%0b stall=%0b exp all 0",
                  load_data, load_valid, load_err, stall_MEM);
      end
      MemRead_MEM = 1'b1; DC_stall = 1'b1;
      #1;
      checks++;
      if (stall_MEM !== 1'b1) begin
         errors++;
         $display("FAIL reset_stall_eq got=%0b exp=1", stall_MEM);
      end
      @(negedge clk);
      MemRead_MEM = 1'b0; DC_stall = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_hits();
      run_load("hit_lw",    32'hDEADBEEF, 3'b010, 2'd0, 0, 0);
      run_load("hit_lb3",   32'h80112233, 3'b000, 2'd3, 0, 0);
      run_load("hit_lbu3",  32'h80112233, 3'b100, 2'd3, 0, 0);
      run_load("hit_lhu2",  32'h80112233, 3'b101, 2'd2, 0, 0);
      run_load("hit_lh0",   32'h00008001, 3'b001, 2'd0, 0, 0);
      run_load("hit_lb1",   32'h12345678, 3'b000, 2'd1, 0, 0);
   endtask

   task automatic test_miss();
      run_load("miss_lh2", 32'hC3A5_1234, 3'b001, 2'd2, 4, 0);
      run_load("miss_hold", 32'h7F00_00FE, 3'b000, 2'd0, 2, 2);
   endtask

   task automatic test_hold();
      run_load("hold_lw", 32'hCAFE_F00D, 3'b010, 2'd0, 0, 3);
   endtask

   task automatic test_errors();
      run_load("err_lw1",  32'hFFFF_FFFF, 3'b010, 2'd1, 0, 0);
      run_load("err_f011", 32'hFFFF_FFFF, 3'b011, 2'd0, 0, 0);
      run_load("err_lhu3", 32'hFFFF_FFFF, 3'b101, 2'd3, 1, 0);
      run_load("err_f111", 32'hFFFF_FFFF, 3'b111, 2'd2, 0, 1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d, w;
      logic        exp_e;
      logic [2:0]  t;
      logic [1:0]  o;
      exp_d = 32'h0; exp_e = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         w = $urandom;
         t = 3'($urandom_range(0, 7));
         o = 2'($urandom_range(0, 3));
         MemRead_MEM = 1'b1; load_type = t; addr_offset = o;
         Dcache_out = w; DC_stall = 1'b0; pipe_stall = 1'b0;
         #1;
         if (k > 0) begin
            checks++;
            if (load_valid !== 1'b1 || load_data !== exp_d || load_err !== exp_e) begin
               errors++;
               $display("FAIL b2b k=%0d valid=%0b data=%h err=%0b exp valid=1 data=%h err=%0b",
                        k, load_valid, load_data, load_err, exp_d, exp_e);
            end
         end
         ref_load(w, t, o, exp_d, exp_e);
      end
      @(negedge clk);
      MemRead_MEM = 1'b0;
      #1;
      checks++;
      if (load_valid !== 1'b1 || load_data !== exp_d || load_err !== exp_e) begin
         errors++;
         $display("FAIL b2b_last valid=%0b data=%h err=%0b exp valid=1 data=%h err=%0b",
                  load_valid, load_data, load_err, exp_d, exp_e);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_wait();
      run_load("pre_rst", 32'h1234_5678, 3'b010, 2'd0, 0, 0);
      @(negedge clk);
      MemRead_MEM = 1'b1; load_type = 3'b010; addr_offset = 2'd0; DC_stall = 1'b1;
      repeat (3) @(negedge clk);
      MemRead_MEM = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (load_data !== 32'h0 || load_valid !== 1'b0 || load_err !== 1'b0 || stall_MEM !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_wait data=%h valid=%0b err=%0b stall=%0b exp all 0",
                  load_data, load_valid, load_err, stall_MEM);
      end
      @(negedge clk);
      rst = 1'b0; DC_stall = 1'b0;
      run_load("post_rst", 32'hA5A5_0F0F, 3'b010, 2'd0, 0, 0);
   endtask

   task automatic test_random();
      logic [31:0] w;
      int          miss, ps;
      for (int n = 0; n < 150; n++) begin
         w    = $urandom;
         miss = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 5));
         ps   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
         run_load("rand", w, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), miss, ps);
      end
   endtask

   initial begin
      test_reset();
      test_hits();
      test_miss();
      test_hold();
      test_errors();
      test_back_to_back();
      test_reset_mid_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_load_unit.md
# dcache_load_unit

Load-return path of the MEM stage: the counterpart of the store-data path that feeds `Dcache_in`. Accepts the 32-bit word returned on `Dcache_out`, waits out D-cache misses, extracts and sign/zero-extends the addressed byte/halfword/word, and presents a registered result to the MEM/WB boundary. Buffers a returned word while the rest of the pipeline is frozen, so no load result is lost or duplicated.

## Interface
Parameters:
- `data_size`: from `` `data_size `` (32). Data width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `MemRead_MEM`  in  1  a load occupies MEM this cycle.
- `load_type`  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `addr_offset`  in  2  effective address [1:0].
- `Dcache_out`  in  `data_size`  word from D-cache, valid when `DC_stall`=0.
- `DC_stall`  in  1  D-cache busy (miss/refill).
- `pipe_stall`  in  1  freeze from any other source (I-cache, hazard).
- `stall_MEM`  out  1  this unit holds the pipeline.
- `load_data`  out  `data_size`  extended load result, registered.
- `load_valid`  out  1  one-cycle pulse, `load_data` is new.
- `load_err`  out  1  registered, with `load_valid`: misaligned or illegal funct3.

## Operation
- States: IDLE, WAIT (miss outstanding), HOLD (word captured, pipeline frozen).
- `load_type`/`addr_offset` latched on the cycle a request is accepted in IDLE; WAIT/HOLD use the latched copy.
- IDLE, `MemRead_MEM`=0: no action.
- IDLE, `MemRead_MEM`=1, `DC_stall`=1 -> WAIT.
- IDLE, request, `DC_stall`=0, `pipe_stall`=0: extract, register, pulse `load_valid` next cycle; stay IDLE.
- IDLE, request, `DC_stall`=0, `pipe_stall`=1 -> HOLD, extracted result captured.
- WAIT, `DC_stall`=1: stay. `DC_stall`=0: capture; `pipe_stall`=0 -> IDLE with `load_valid` pulse next cycle; `pipe_stall`=1 -> HOLD.
- HOLD: `pipe_stall`=0 -> IDLE, `load_valid` pulses next cycle with held data. New requests ignored while in WAIT/HOLD.
- `stall_MEM` = (state==WAIT) | (IDLE & `MemRead_MEM` & `DC_stall`); combinational, never depends on `pipe_stall`.
- Extraction: byte = word[8*off+7:8*off]; half = word[16*off[1]+15:16*off[1]]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
- Error: LH/LHU with off[0]=1, LW with off!=0, or funct3 in {011,110,111} -> `load_err`=1, `load_data`=0.

## Timing
- Reset (any state, including mid-WAIT/HOLD): state IDLE, `load_data`=0, `load_valid`=0, `load_err`=0, latched fields 0; `stall_MEM` follows IDLE equation.
- Hit latency: `load_valid` 1 cycle after request cycle.
- Miss latency: `load_valid` 1 cycle after first cycle with `DC_stall`=0 (if `pipe_stall`=0).
- `load_data`/`load_err` hold value between pulses; exactly one `load_valid` per accepted load.
- `DC_stall` and `pipe_stall` falling same cycle in WAIT: go straight IDLE, pulse next cycle.

## Structure
- `define.sv`: funct3 load codes (`` `LB `` … `` `LHU ``); state typedef `ld_state_t` {IDLE, WAIT, HOLD}.
- Sub-module `load_extend`: combinational (word, type, offset) -> (data, err); instantiated once; FSM/registers in top.

## Test plan
- Hit LW off 0, word 0xDEADBEEF -> next cycle `load_valid`=1, `load_data`=0xDEADBEEF, `stall_MEM` never high.
- Hit LB off 3 word 0x80112233 -> 0xFFFFFF80; LBU -> 0x00000080; LHU off 2 -> 0x00008011; LH off 0 word 0x00008001 -> 0xFFFF8001.
- Miss: `DC_stall` high 4 cycles after LH off 2 -> `stall_MEM` high those 4 cycles, one `load_valid` the cycle after release with correct data.
- Hit with `pipe_stall` high 3 cycles, `Dcache_out` changed to garbage meanwhile -> HOLD, pulse after `pipe_stall` falls with original data.
- LW off 1 and funct3 011 -> `load_err`=1, `load_data`=0, single pulse.
- `rst` asserted mid-WAIT -> outputs 0 immediately, IDLE; subsequent hit LW completes normally.
